// File: rtl/game_controller.sv
// Tic-tac-toe game controller: owns the board register and the turn sequence.
// It accepts moves over a valid/ready handshake, rejects illegal moves, writes
// legal ones, alternates turns and decides the result (win, draw or none yet).
// Every output comes straight from a flop.

module game_controller #(
    parameter logic FIRST_PLAYER = 1'b0,
    parameter logic ALT_START    = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mv_valid,
    input  logic [1:0]  mv_row,
    input  logic [1:0]  mv_col,
    output logic        mv_ready,
    output logic        mv_err,
    output logic [17:0] board_flat,
    output logic        cur_player,
    output logic [3:0]  move_cnt,
    output logic [2:0]  who_won,
    output logic        game_over
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TURN  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [17:0] BOARD_EMPTY = 18'h2AAAA;
    localparam logic [1:0]  CELL_EMPTY  = 2'd2;
    localparam logic [2:0]  RES_DRAW    = 3'd2;
    localparam logic [2:0]  RES_NONE    = 3'd3;

    // Returns 1 when player p owns all three cells of any row, column or diagonal.
    function automatic logic line_hit(input logic [17:0] b, input logic p);
        logic [8:0] own;
        for (int i = 0; i < 9; i++) begin
            own[i] = (b[(i * 2) +: 2] == {1'b0, p});
        end
        return (&own[2:0]) | (&own[5:3]) | (&own[8:6]) |
               (own[0] & own[3] & own[6]) |
               (own[1] & own[4] & own[7]) |
               (own[2] & own[5] & own[8]) |
               (own[0] & own[4] & own[8]) |
               (own[2] & own[4] & own[6]);
    endfunction

    state_t      state_r, state_nx_s;
    logic [17:0] board_r, board_nx_s;
    logic        cur_player_r, cur_player_nx_s;
    logic [3:0]  move_cnt_r, move_cnt_nx_s;
    logic [2:0]  who_won_r, who_won_nx_s;
    logic        game_over_r, game_over_nx_s;
    logic        mv_ready_r, mv_ready_nx_s;
    logic        mv_err_r, mv_err_nx_s;
    logic        first_r, first_nx_s;     // first player of the current game
    logic        played_r, played_nx_s;   // a game has been started since reset

    logic        in_range_s;
    logic [3:0]  mv_idx_s;
    logic        cell_free_s;
    logic        handshake_s;
    logic        legal_s;
    logic        win_s;
    logic        draw_s;
    logic        new_first_s;

    // Decode the requested cell; out-of-range coordinates are parked on cell 0
    // so the board lookup never leaves the vector.
    always_comb begin
        in_range_s = (mv_row != 2'd3) && (mv_col != 2'd3);
        if (in_range_s) begin
            mv_idx_s = ({2'b00, mv_row} * 4'd3) + {2'b00, mv_col};
        end else begin
            mv_idx_s = 4'd0;
        end
        cell_free_s = (board_r[{mv_idx_s, 1'b0} +: 2] == CELL_EMPTY);
        handshake_s = mv_valid && mv_ready_r;
        legal_s     = in_range_s && cell_free_s;
        win_s       = line_hit(board_r, cur_player_r);
        draw_s      = (move_cnt_r == 4'd9);
        if (ALT_START && played_r) begin
            new_first_s = ~first_r;
        end else begin
            new_first_s = FIRST_PLAYER;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; start overrides everything, including a pending move.
    always_comb begin
        state_nx_s = state_r;
        if (start) begin
            state_nx_s = ST_TURN;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nx_s = ST_IDLE;
                end
                ST_TURN: begin
                    if (handshake_s && legal_s) begin
                        state_nx_s = ST_CHECK;
                    end else begin
                        state_nx_s = ST_TURN;
                    end
                end
                ST_CHECK: begin
                    if (win_s || draw_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_TURN;
                    end
                end
                ST_DONE: begin
                    state_nx_s = ST_DONE;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // Next values of the registered outputs and game bookkeeping.
    always_comb begin
        board_nx_s      = board_r;
        cur_player_nx_s = cur_player_r;
        move_cnt_nx_s   = move_cnt_r;
        who_won_nx_s    = who_won_r;
        game_over_nx_s  = game_over_r;
        mv_err_nx_s     = 1'b0;
        first_nx_s      = first_r;
        played_nx_s     = played_r;
        mv_ready_nx_s   = (state_nx_s == ST_TURN);
        if (start) begin
            board_nx_s      = BOARD_EMPTY;
            move_cnt_nx_s   = 4'd0;
            who_won_nx_s    = RES_NONE;
            game_over_nx_s  = 1'b0;
            cur_player_nx_s = new_first_s;
            first_nx_s      = new_first_s;
            played_nx_s     = 1'b1;
        end else begin
            case (state_r)
                ST_TURN: begin
                    if (handshake_s && legal_s) begin
                        board_nx_s[{mv_idx_s, 1'b0} +: 2] = {1'b0, cur_player_r};
                        move_cnt_nx_s = move_cnt_r + 4'd1;
                    end else if (handshake_s) begin
                        mv_err_nx_s = 1'b1;
                    end else begin
                        mv_err_nx_s = 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (win_s) begin
                        who_won_nx_s   = {2'b00, cur_player_r};
                        game_over_nx_s = 1'b1;
                    end else if (draw_s) begin
                        who_won_nx_s   = RES_DRAW;
                        game_over_nx_s = 1'b1;
                    end else begin
                        cur_player_nx_s = ~cur_player_r;
                    end
                end
                default: begin
                    mv_err_nx_s = 1'b0;
                end
            endcase
        end
    end

    // Output and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board_r      <= BOARD_EMPTY;
            cur_player_r <= FIRST_PLAYER;
            move_cnt_r   <= 4'd0;
            who_won_r    <= RES_NONE;
            game_over_r  <= 1'b0;
            mv_ready_r   <= 1'b0;
            mv_err_r     <= 1'b0;
            first_r      <= FIRST_PLAYER;
            played_r     <= 1'b0;
        end else begin
            board_r      <= board_nx_s;
            cur_player_r <= cur_player_nx_s;
            move_cnt_r   <= move_cnt_nx_s;
            who_won_r    <= who_won_nx_s;
            game_over_r  <= game_over_nx_s;
            mv_ready_r   <= mv_ready_nx_s;
            mv_err_r     <= mv_err_nx_s;
            first_r      <= first_nx_s;
            played_r     <= played_nx_s;
        end
    end

    assign board_flat = board_r;
    assign cur_player = cur_player_r;
    assign move_cnt   = move_cnt_r;
    assign who_won    = who_won_r;
    assign game_over  = game_over_r;
    assign mv_ready   = mv_ready_r;
    assign mv_err     = mv_err_r;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller (FIRST_PLAYER=0, ALT_START=1).
// A cell-array game model predicts every output after every clock edge.

module tb_game_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mv_valid = 1'b0;
    logic [1:0]  mv_row = 2'd0;
    logic [1:0]  mv_col = 2'd0;
    logic        mv_ready;
    logic        mv_err;
    logic [17:0] board_flat;
    logic        cur_player;
    logic [3:0]  move_cnt;
    logic [2:0]  who_won;
    logic        game_over;

    game_controller #(
        .FIRST_PLAYER(1'b0),
        .ALT_START   (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mv_valid  (mv_valid),
        .mv_row    (mv_row),
        .mv_col    (mv_col),
        .mv_ready  (mv_ready),
        .mv_err    (mv_err),
        .board_flat(board_flat),
        .cur_player(cur_player),
        .move_cnt  (move_cnt),
        .who_won   (who_won),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Game model: phases 0=idle 1=awaiting move 2=judging 3=finished.
    int m_cell [9];
    int m_player, m_cnt, m_won, m_over, m_err, m_phase, m_first, m_played;
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_wins(input int p);
        for (int l = 0; l < 8; l++) begin
            if (m_cell[lines[l][0]] == p && m_cell[lines[l][1]] == p && m_cell[lines[l][2]] == p)
                return 1;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_cell[i] = 2;
        m_player = 0; m_cnt = 0; m_won = 3; m_over = 0; m_err = 0;
        m_phase = 0; m_first = 0; m_played = 0;
    endtask

    task automatic model_edge(input int s, input int v, input int r, input int c);
        int nf;
        m_err = 0;
        if (s != 0) begin
            nf = (m_played != 0) ? 1 - m_first : 0;
            m_first = nf; m_played = 1; m_player = nf;
            for (int i = 0; i < 9; i++) m_cell[i] = 2;
            m_cnt = 0; m_won = 3; m_over = 0; m_phase = 1;
        end else if (m_phase == 1) begin
            if (v != 0) begin
                if (r == 3 || c == 3 || m_cell[r * 3 + c] != 2) begin
                    m_err = 1;
                end else begin
                    m_cell[r * 3 + c] = m_player;
                    m_cnt++;
                    m_phase = 2;
                end
            end
        end else if (m_phase == 2) begin
            if (model_wins(m_player) != 0) begin
                m_won = m_player; m_over = 1; m_phase = 3;
            end else if (m_cnt == 9) begin
                m_won = 2; m_over = 1; m_phase = 3;
            end else begin
                m_player = 1 - m_player; m_phase = 1;
            end
        end
    endtask

    task automatic compare_all();
        logic [17:0] eb;
        logic [31:0] cv;
        for (int i = 0; i < 9; i++) begin
            cv = m_cell[i];
            eb[i * 2 +: 2] = cv[1:0];
        end
        check_val("board_flat", {14'd0, board_flat}, {14'd0, eb});
        check_val("cur_player", {31'd0, cur_player}, m_player);
        check_val("move_cnt",   {28'd0, move_cnt},   m_cnt);
        check_val("who_won",    {29'd0, who_won},    m_won);
        check_val("game_over",  {31'd0, game_over},  m_over);
        check_val("mv_ready",   {31'd0, mv_ready},   (m_phase == 1) ? 1 : 0);
        check_val("mv_err",     {31'd0, mv_err},     m_err);
    endtask

    // Drive one cycle of inputs at the falling edge, then check after the rising edge.
    task automatic step(input int s, input int v, input int r, input int c);
        @(negedge clk);
        start    = (s != 0);
        mv_valid = (v != 0);
        mv_row   = r[1:0];
        mv_col   = c[1:0];
        @(posedge clk);
        model_edge(s, v, r, c);
        #1;
        compare_all();
    endtask

    task automatic play_move(input int r, input int c);
        step(0, 1, r, c);
        step(0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check_val("reset_board", {14'd0, board_flat}, 32'h2AAAA);
        @(negedge clk);
        rst_n = 1'b1;

        // Game 1 (P1 first): P1 wins down column 0.
        step(1, 0, 0, 0);
        play_move(0, 0); play_move(0, 1); play_move(1, 0); play_move(0, 2); play_move(2, 0);
        check_val("win_who_won",  {29'd0, who_won},  0);
        check_val("win_game_over", {31'd0, game_over}, 1);
        check_val("win_move_cnt", {28'd0, move_cnt}, 5);
        check_val("win_cell00",   {30'd0, board_flat[1:0]},   0);
        check_val("win_cell20",   {30'd0, board_flat[13:12]}, 0);
        // Moves while finished are ignored without an error pulse.
        step(0, 1, 1, 1); step(0, 1, 2, 2); step(0, 0, 0, 0);

        // Game 2 (P2 first): illegal moves, then a full-board draw.
        step(1, 0, 0, 0);
        check_val("game2_first", {31'd0, cur_player}, 1);
        play_move(0, 0);
        step(0, 1, 0, 0);
        check_val("occupied_err",   {31'd0, mv_err},   1);
        check_val("occupied_ready", {31'd0, mv_ready}, 1);
        step(0, 0, 0, 0);
        check_val("err_one_cycle", {31'd0, mv_err}, 0);
        step(0, 1, 3, 1);
        check_val("row3_err", {31'd0, mv_err}, 1);
        step(0, 0, 0, 0);
        play_move(0, 1); play_move(0, 2); play_move(1, 1); play_move(1, 0);
        play_move(1, 2); play_move(2, 1); play_move(2, 0); play_move(2, 2);
        check_val("draw_who_won",  {29'd0, who_won},  2);
        check_val("draw_move_cnt", {28'd0, move_cnt}, 9);

        // Game 3 (P1 first): ninth move completes the main diagonal.
        step(1, 0, 0, 0);
        play_move(0, 0); play_move(0, 1); play_move(0, 2); play_move(1, 0);
        play_move(1, 1); play_move(1, 2); play_move(2, 1); play_move(2, 0); play_move(2, 2);
        check_val("win9_who_won",  {29'd0, who_won},  0);
        check_val("win9_move_cnt", {28'd0, move_cnt}, 9);

        // Game 4 aborted by start colliding with a legal move.
        step(1, 0, 0, 0);
        play_move(1, 1); play_move(0, 0);
        step(1, 1, 2, 2);
        check_val("abort_board", {14'd0, board_flat}, 32'h2AAAA);
        check_val("abort_cnt",   {28'd0, move_cnt},   0);
        check_val("abort_first", {31'd0, cur_player}, 0);

        // mv_valid held high with random targets.
        for (int i = 0; i < 24; i++) step(0, 1, $urandom_range(0, 2), $urandom_range(0, 2));

        // Reset asserted while judging a move.
        step(1, 0, 0, 0);
        step(0, 1, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0);
        check_val("post_reset_first", {31'd0, cur_player}, 0);

        // Randomized play with occasional restarts.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 39) == 0) ? 1 : 0,
                 ($urandom_range(0, 9) < 7) ? 1 : 0,
                 $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
